stat_run_ctrl: RTL and testbench

- Run/halt/single-step controller for the MIPS CPU.
- Generates the CPU clock-enable from button-level go/step/clear inputs and the CPU's halt (syscall) signal.
- Owns the 16-bit statistics counters: total cycles, unconditional jumps, conditional branches and taken branches.
- Drives a selectable counter value to the display path; replaces standalone free-running counters.

---
 rtl/stat_run_ctrl_if.sv | 27 ++
 rtl/stat_run_ctrl.sv | 109 ++++++++++
 tb/tb_stat_run_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/stat_run_ctrl_if.sv
// Control/status bundle between the stats/run controller and its host.
// master drives buttons, CPU events and select; slave is the controller.
`timescale 1ns/1ps
interface stat_run_ctrl_if #(parameter int WIDTH = 16);
  logic             go;
  logic             step;
  logic             clr;
  logic             halt;
  logic             ev_jmp;
  logic             ev_br;
  logic             ev_br_taken;
  logic [1:0]       sel;
  logic             cpu_en;
  logic [1:0]       state;
  logic [WIDTH-1:0] count_out;
  logic             ovf;

  modport master (
    output go, step, clr, halt, ev_jmp, ev_br, ev_br_taken, sel,
    input  cpu_en, state, count_out, ovf
  );

  modport slave (
    input  go, step, clr, halt, ev_jmp, ev_br, ev_br_taken, sel,
    output cpu_en, state, count_out, ovf
  );
endinterface

// File: rtl/stat_run_ctrl.sv
// Run/halt/single-step controller for the MIPS CPU with cycle, jump,
// branch and taken-branch statistics counters.
//
// state | meaning
// IDLE  | stopped after reset or clear, waiting for go or step
// RUN   | CPU clocked every cycle until halt
// HALT  | CPU stopped by halt or after a step; go resumes, step steps
// STEP  | exactly one enabled CPU cycle, then HALT
`timescale 1ns/1ps
module stat_run_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  stat_run_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    STEP = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  state_t           state_d;
  logic             go_q;
  logic             step_q;
  logic             go_rise;
  logic             step_rise;
  logic             en;
  logic [3:0]       inc;
  logic             wrap;
  logic [WIDTH-1:0] cnt_q [4];
  logic             ovf_q;

  assign go_rise   = bus.go & ~go_q;
  assign step_rise = bus.step & ~step_q;
  assign en        = (state_q == RUN) || (state_q == STEP);

  // Counter index order matches sel: cycles, jumps, branches, taken.
  assign inc = {bus.ev_br & bus.ev_br_taken, bus.ev_br, bus.ev_jmp, 1'b1};

  always_comb begin
    wrap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (inc[i] && (cnt_q[i] == '1)) wrap = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (go_rise)        state_d = RUN;
          else if (step_rise) state_d = STEP;
        end
        RUN: begin
          if (bus.halt) state_d = HALT;
        end
        HALT: begin
          if (go_rise)        state_d = RUN;
          else if (step_rise) state_d = STEP;
        end
        STEP:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Edge detectors reset high so a button held through reset never fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      go_q    <= 1'b1;
      step_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      go_q    <= bus.go;
      step_q  <= bus.step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      ovf_q <= 1'b0;
    end else if (bus.clr) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (inc[i]) cnt_q[i] <= cnt_q[i] + ONE;
      end
      if (wrap) ovf_q <= 1'b1;
    end
  end

  assign bus.cpu_en    = en;
  assign bus.state     = state_q;
  assign bus.count_out = cnt_q[bus.sel];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_stat_run_ctrl.sv
// Directed bench for stat_run_ctrl: expectations are queued when stimulus
// is driven and popped against DUT outputs one cycle later.
`timescale 1ns/1ps
module tb_stat_run_ctrl;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stat_run_ctrl_if #(.WIDTH(WIDTH)) bus ();
  stat_run_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input string tag, input logic [WIDTH-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [WIDTH-1:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_state();
    pop_check({{(WIDTH-2){1'b0}}, bus.state});
  endtask

  task automatic chk_en();
    pop_check({{(WIDTH-1){1'b0}}, bus.cpu_en});
  endtask

  task automatic chk_ovf();
    pop_check({{(WIDTH-1){1'b0}}, bus.ovf});
  endtask

  task automatic chk_cnt(input logic [1:0] s);
    bus.sel = s;
    #1;
    pop_check(bus.count_out);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.go = 1'b1; bus.step = 1'b0; bus.clr = 1'b0; bus.halt = 1'b0;
    bus.ev_jmp = 1'b0; bus.ev_br = 1'b0; bus.ev_br_taken = 1'b0;
    bus.sel = 2'd0;

    // reset with go held high
    push("rst_state", 0); push("rst_en", 0); push("rst_cnt", 0); push("rst_ovf", 0);
    tick(2);
    chk_state(); chk_en(); chk_cnt(0); chk_ovf();
    rst = 1'b1;
    push("held_go_state", 0); push("held_go_en", 0);
    tick(5);
    chk_state(); chk_en();
    bus.go = 1'b0;
    tick();
    bus.go = 1'b1;
    push("go_run_state", 1); push("go_run_en", 1);
    tick();
    chk_state(); chk_en();

    // 10 run cycles with branch events
    push("run10_cycles", 10); push("run10_jumps", 0);
    push("run10_br", 2); push("run10_taken", 2);
    for (int i = 1; i <= 10; i++) begin
      bus.ev_br       = (i == 3 || i == 7);
      bus.ev_br_taken = (i == 3 || i == 5 || i == 7);
      tick();
    end
    bus.ev_br = 1'b0; bus.ev_br_taken = 1'b0;
    chk_cnt(0); chk_cnt(1); chk_cnt(2); chk_cnt(3);
    bus.sel = 2'd0;

    // halt together with a jump
    bus.halt = 1'b1; bus.ev_jmp = 1'b1;
    push("halt_state", 2); push("halt_en", 0); push("halt_jumps", 1); push("halt_cycles", 11);
    tick();
    bus.halt = 1'b0; bus.ev_jmp = 1'b0;
    chk_state(); chk_en(); chk_cnt(1); chk_cnt(0);
    bus.go = 1'b0;
    tick();
    bus.go = 1'b1;
    push("resume_state", 1); push("resume_jumps", 1); push("resume_cycles", 11);
    tick();
    chk_state(); chk_cnt(1); chk_cnt(0);
    bus.halt = 1'b1;
    push("rehalt_state", 2); push("rehalt_cycles", 12);
    tick();
    bus.halt = 1'b0;
    chk_state(); chk_cnt(0);

    // two single steps from HALT
    bus.step = 1'b1;
    push("step1_state", 3); push("step1_en", 1); push("step1_cycles", 12);
    tick();
    chk_state(); chk_en(); chk_cnt(0);
    push("step1_back_state", 2); push("step1_back_en", 0); push("step1_back_cycles", 13);
    tick();
    chk_state(); chk_en(); chk_cnt(0);
    push("step_held_state", 2);
    tick();
    chk_state();
    bus.step = 1'b0;
    tick();
    bus.step = 1'b1;
    push("step2_state", 3);
    tick();
    chk_state();
    push("step2_back_state", 2); push("step2_cycles", 14);
    tick();
    chk_state(); chk_cnt(0);
    bus.step = 1'b0;

    // counter wrap and sticky overflow
    bus.clr = 1'b1;
    push("clr_state", 0); push("clr_cycles", 0);
    tick();
    bus.clr = 1'b0;
    chk_state(); chk_cnt(0);
    bus.go = 1'b0;
    tick();
    bus.go = 1'b1;
    push("wrap_run_state", 1);
    tick();
    chk_state();
    push("pre_wrap_cycles", 16'hFFFE); push("pre_wrap_ovf", 0);
    tick(65534);
    chk_cnt(0); chk_ovf();
    push("wrap_cycles", 0); push("wrap_ovf", 1);
    tick(2);
    chk_cnt(0); chk_ovf();
    push("post_wrap_cycles", 3); push("post_wrap_ovf", 1);
    tick(3);
    chk_cnt(0); chk_ovf();
    bus.clr = 1'b1;
    push("wrap_clr_state", 0); push("wrap_clr_ovf", 0); push("wrap_clr_cycles", 0);
    tick();
    bus.clr = 1'b0;
    chk_state(); chk_ovf(); chk_cnt(0);

    // clear beats halt, go_rise and events in RUN
    bus.go = 1'b0;
    tick();
    bus.go = 1'b1; bus.ev_jmp = 1'b1;
    tick();
    push("pre_clr_jumps", 4);
    tick(3);
    bus.go = 1'b0;
    tick();
    chk_cnt(1);
    bus.go = 1'b1; bus.clr = 1'b1; bus.halt = 1'b1;
    push("clr_win_state", 0); push("clr_win_en", 0);
    push("clr_win_cycles", 0); push("clr_win_jumps", 0);
    tick();
    bus.clr = 1'b0; bus.halt = 1'b0; bus.ev_jmp = 1'b0;
    chk_state(); chk_en(); chk_cnt(0); chk_cnt(1);

    // asynchronous reset while stepping
    bus.sel = 2'd0;
    bus.step = 1'b1;
    push("pre_rst_state", 3); push("pre_rst_en", 1);
    tick();
    chk_state(); chk_en();
    rst = 1'b0;
    push("async_rst_en", 0); push("async_rst_state", 0);
    #1;
    chk_en(); chk_state();
    bus.step = 1'b0;
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
